// File: rtl/barrel_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings, fill modes,
// and the per-stage control payload.
package barrel_pkg;

   localparam logic [2:0] OP_LSL = 3'b000;
   localparam logic [2:0] OP_LSR = 3'b001;
   localparam logic [2:0] OP_ASR = 3'b010;
   localparam logic [2:0] OP_ROR = 3'b011;
   localparam logic [2:0] OP_ROL = 3'b100;

   typedef enum logic [1:0] {
      FILL_ZERO,
      FILL_SIGN,
      FILL_WRAP
   } fill_e;

   // Control half of the stage payload; data and remaining shamt are width-dependent
   // and are wrapped around this in the top level.
   typedef struct packed {
      logic [2:0] op;
      logic       carry;
      logic       sign;
      logic       zero;
      logic       valid;
   } stage_ctrl_t;

   function automatic logic is_left(input logic [2:0] op);
      return (op == OP_LSL) || (op == OP_ROL);
   endfunction

   function automatic fill_e fill_of(input logic [2:0] op);
      case (op)
         OP_ASR:         return FILL_SIGN;
         OP_ROR, OP_ROL: return FILL_WRAP;
         default:        return FILL_ZERO;
      endcase
   endfunction

endpackage

// File: rtl/barrel_level.sv
// One log-shifter level: conditional right shift by 2^K with selectable fill.
module barrel_level
   import barrel_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned K     = 0
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic             en_i,
   input  fill_e            fill_i,
   input  logic             sign_i,
   output logic [WIDTH-1:0] data_o
);

   localparam int unsigned S = 1 << K;

   logic [WIDTH-1:0] fill_v;

   always_comb begin
      fill_v = '0;
      case (fill_i)
         FILL_WRAP: fill_v = data_i << (WIDTH - S);
         FILL_SIGN: fill_v = {WIDTH{sign_i}} << (WIDTH - S);
         default:   fill_v = '0;
      endcase
      data_o = en_i ? ((data_i >> S) | fill_v) : data_i;
   end

endmodule

// File: rtl/barrel_pipe.sv
// Pipelined barrel shifter (lsl/lsr/asr/ror/rol) with carry and zero flags,
// log-shifter levels spread over PIPE register stages behind valid/ready.
module barrel_pipe
   import barrel_pkg::*;
#(
   parameter  int unsigned WIDTH = 16,
   parameter  int unsigned PIPE  = 2,
   localparam int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [SHW-1:0]   in_shamt,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_carry,
   output logic             out_zero
);

   localparam int unsigned LPS = (SHW + PIPE - 1) / PIPE;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [SHW-1:0]   shamt;
      stage_ctrl_t      ctrl;
   } stage_t;

   stage_t           st_in [PIPE];
   stage_t           st_q  [PIPE];
   stage_t           s0_d;
   logic             en;
   logic             in_pass;
   logic [WIDTH-1:0] in_rev;
   logic [SHW-1:0]   shm1;

   assign out_valid = st_q[PIPE-1].ctrl.valid;
   assign out_data  = st_q[PIPE-1].data;
   assign out_carry = st_q[PIPE-1].ctrl.carry;
   assign out_zero  = st_q[PIPE-1].ctrl.zero;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   assign in_rev  = {<<{in_data}};
   assign shm1    = in_shamt - SHW'(1);
   assign in_pass = in_op > OP_ROL;

   // Left ops run on the bit-reversed operand, so data[WIDTH-shamt] becomes rev[shamt-1]
   // and one carry tap serves every op.
   always_comb begin
      s0_d            = '0;
      s0_d.data       = is_left(in_op) ? in_rev : in_data;
      s0_d.shamt      = in_pass ? '0 : in_shamt;
      s0_d.ctrl.op    = in_op;
      s0_d.ctrl.sign  = in_data[WIDTH-1];
      s0_d.ctrl.valid = in_valid;
      s0_d.ctrl.carry = (s0_d.shamt != '0) ? s0_d.data[shm1] : 1'b0;
   end

   for (genvar s = 0; s < PIPE; s++) begin : g_stage
      localparam int unsigned FIRST = s * LPS;

      logic [WIDTH-1:0] chain [LPS+1];
      stage_t           nxt;
      stage_t           q_q;

      if (s == 0) begin : g_src_in
         assign st_in[s] = s0_d;
      end else begin : g_src_reg
         assign st_in[s] = st_q[s-1];
      end

      assign chain[0] = st_in[s].data;

      for (genvar j = 0; j < LPS; j++) begin : g_lvl
         if (FIRST + j < SHW) begin : g_on
            barrel_level #(
               .WIDTH(WIDTH),
               .K    (FIRST + j)
            ) u_level (
               .data_i(chain[j]),
               .en_i  (st_in[s].shamt[FIRST + j]),
               .fill_i(fill_of(st_in[s].ctrl.op)),
               .sign_i(st_in[s].ctrl.sign),
               .data_o(chain[j+1])
            );
         end else begin : g_off
            assign chain[j+1] = chain[j];
         end
      end

      if (s == PIPE - 1) begin : g_last
         logic [WIDTH-1:0] res_rev;
         assign res_rev = {<<{chain[LPS]}};
         always_comb begin
            nxt           = st_in[s];
            nxt.data      = is_left(st_in[s].ctrl.op) ? res_rev : chain[LPS];
            nxt.ctrl.zero = (nxt.data == '0);
         end
      end else begin : g_mid
         always_comb begin
            nxt      = st_in[s];
            nxt.data = chain[LPS];
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            q_q <= '0;
         end else if (en) begin
            q_q.ctrl.valid <= nxt.ctrl.valid;
            if (nxt.ctrl.valid) begin
               q_q <= nxt;
            end
         end
      end

      assign st_q[s] = q_q;
   end

endmodule
